// File: rtl/countdown_timer_ctrl_if.sv
// Pin bundle for the countdown timer: debounced buttons and interlock in,
// display, indicator LEDs, motor phases and done flag out.
interface countdown_timer_ctrl_if;
  logic       btn_set;
  logic       btn_up;
  logic       btn_start;
  logic       sensor;
  logic [6:0] seg;
  logic [3:0] an;
  logic [3:0] leds;
  logic [3:0] motor;
  logic       done;

  modport master (
    output btn_set, btn_up, btn_start, sensor,
    input  seg, an, leds, motor, done
  );

  modport slave (
    input  btn_set, btn_up, btn_start, sensor,
    output seg, an, leds, motor, done
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// MM:SS countdown timer: button-driven set mode, run/pause/done FSM, stepper
// drive while running and a multiplexed 4-digit display with field blinking.
module countdown_timer_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int SCAN_DIV  = 62_500,
  parameter int BLINK_DIV = 10_000_000,
  parameter int STEP_DIV  = 250_000,
  parameter int MAX_MIN   = 59
) (
  input  logic                 clk,
  input  logic                 rst_n,
  countdown_timer_ctrl_if.slave bus
);

  localparam int TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int STEP_W  = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;

  typedef enum logic [2:0] {IDLE, SET_MIN, SET_SEC, RUN, PAUSE, DONE} state_t;

  state_t state, state_nx;

  logic [6:0] min;
  logic [5:0] sec;

  // Button sync and rising-edge detect; bit order {set, start, up}
  logic [2:0] btn_q, btn_d, rise;
  logic       sensor_q;
  logic       set_p, start_p, up_p, any_p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q    <= '0;
      btn_d    <= '0;
      sensor_q <= 1'b0;
    end else begin
      btn_q    <= {bus.btn_set, bus.btn_start, bus.btn_up};
      btn_d    <= btn_q;
      sensor_q <= bus.sensor;
    end
  end

  assign rise    = btn_q & ~btn_d;
  assign set_p   = rise[2];
  assign start_p = rise[1] & ~rise[2];
  assign up_p    = rise[0] & ~(|rise[2:1]);
  assign any_p   = |rise;

  logic [TICK_W-1:0] tick_cnt;
  logic tick_wrap, tick, pause_req, time_zero, last_sec;

  assign tick_wrap = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign pause_req = sensor_q | start_p;
  // Pause wins over a coincident tick, so the second is not consumed
  assign tick      = (state == RUN) && !pause_req && tick_wrap;
  assign time_zero = (min == 7'd0) && (sec == 6'd0);
  assign last_sec  = (min == 7'd0) && (sec == 6'd1);

  always_ff @(posedge clk) begin
    if (!rst_n || (state != RUN && state != PAUSE))
      tick_cnt <= '0;
    else if (state == RUN && !pause_req)
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (set_p) state_nx = SET_MIN;
               else if (start_p && !time_zero) state_nx = RUN;
      SET_MIN: if (set_p) state_nx = SET_SEC;
      SET_SEC: if (set_p) state_nx = IDLE;
      RUN:     if (pause_req) state_nx = PAUSE;
               else if (tick && last_sec) state_nx = DONE;
      PAUSE:   if (set_p) state_nx = IDLE;
               else if (start_p && !sensor_q) state_nx = RUN;
      DONE:    if (any_p) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min <= '0;
      sec <= '0;
    end else begin
      case (state)
        SET_MIN: if (up_p) min <= (min == 7'(MAX_MIN)) ? '0 : min + 1'b1;
        SET_SEC: if (up_p) sec <= (sec == 6'd59) ? '0 : sec + 1'b1;
        RUN: if (tick) begin
          if (sec == 6'd0) begin
            sec <= 6'd59;
            min <= min - 1'b1;
          end else begin
            sec <= sec - 1'b1;
          end
        end
        DONE: if (any_p) begin
          min <= '0;
          sec <= '0;
        end
        default: ;
      endcase
    end
  end

  // Stepper position survives PAUSE; only finishing a countdown rewinds it
  logic [STEP_W-1:0] step_cnt;
  logic [1:0]        step_idx;

  always_ff @(posedge clk) begin
    if (!rst_n || state_nx == DONE) begin
      step_cnt <= '0;
      step_idx <= '0;
    end else if (state == RUN) begin
      if (step_cnt == STEP_W'(STEP_DIV - 1)) begin
        step_cnt <= '0;
        step_idx <= step_idx + 1'b1;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         scan_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_hide;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt   <= '0;
      scan_idx   <= '0;
      blink_cnt  <= '0;
      blink_hide <= 1'b0;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt  <= '0;
        blink_hide <= ~blink_hide;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h7E;
      4'd1:    return 7'h30;
      4'd2:    return 7'h6D;
      4'd3:    return 7'h79;
      4'd4:    return 7'h33;
      4'd5:    return 7'h5B;
      4'd6:    return 7'h5F;
      4'd7:    return 7'h70;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  logic [3:0] min_t, min_u, sec_t, sec_u, digit;

  assign min_t = 4'(min / 7'd10);
  assign min_u = 4'(min % 7'd10);
  assign sec_t = 4'(sec / 6'd10);
  assign sec_u = 4'(sec % 6'd10);

  always_comb begin
    case (scan_idx)
      2'd3:    digit = min_t;
      2'd2:    digit = min_u;
      2'd1:    digit = sec_t;
      default: digit = sec_u;
    endcase
  end

  logic [3:0] leds_nx, motor_nx, blink_mask;
  logic       done_nx;

  always_comb begin
    leds_nx    = '0;
    motor_nx   = '0;
    blink_mask = '0;
    done_nx    = 1'b0;
    case (state)
      SET_MIN: begin leds_nx = 4'b0001; blink_mask = 4'b1100; end
      SET_SEC: begin leds_nx = 4'b0010; blink_mask = 4'b0011; end
      RUN: begin
        leds_nx = 4'b0100;
        case (step_idx)
          2'd0:    motor_nx = 4'b1100;
          2'd1:    motor_nx = 4'b0110;
          2'd2:    motor_nx = 4'b0011;
          default: motor_nx = 4'b1001;
        endcase
      end
      PAUSE:   leds_nx = 4'b1000;
      DONE:    begin done_nx = 1'b1; blink_mask = 4'b1111; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.seg   <= '0;
      bus.an    <= '0;
      bus.leds  <= '0;
      bus.motor <= '0;
      bus.done  <= 1'b0;
    end else begin
      bus.an    <= 4'b0001 << scan_idx;
      bus.seg   <= (blink_mask[scan_idx] && blink_hide) ? 7'h00 : seg_decode(digit);
      bus.leds  <= leds_nx;
      bus.motor <= motor_nx;
      bus.done  <= done_nx;
    end
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with shortened dividers.
module tb_countdown_timer_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  countdown_timer_ctrl_if bus();

  countdown_timer_ctrl #(
    .TICK_DIV(20), .SCAN_DIV(2), .BLINK_DIV(8), .STEP_DIV(5), .MAX_MIN(59)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle pulse; returns just after the edge on which the press acts
  task automatic press(input bit s, input bit u, input bit st);
    bus.btn_set = s; bus.btn_up = u; bus.btn_start = st;
    cyc(1);
    bus.btn_set = 0; bus.btn_up = 0; bus.btn_start = 0;
    cyc(1);
  endtask

  task automatic set_time(input int cm, input int cs, input int m, input int s);
    press(1, 0, 0);
    repeat ((m - cm + 60) % 60) press(0, 1, 0);
    press(1, 0, 0);
    repeat ((s - cs + 60) % 60) press(0, 1, 0);
    press(1, 0, 0);
  endtask

  function automatic int seg2dig(input logic [6:0] s);
    case (s)
      7'h7E: return 0;  7'h30: return 1;  7'h6D: return 2;  7'h79: return 3;
      7'h33: return 4;  7'h5B: return 5;  7'h5F: return 6;  7'h70: return 7;
      7'h7F: return 8;  7'h7B: return 9;
      default: return -1;
    endcase
  endfunction

  task automatic read_disp(output int mm, output int ss);
    int d [4];
    d = '{-1, -1, -1, -1};
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      for (int j = 0; j < 4; j++) if (bus.an[j]) d[j] = seg2dig(bus.seg);
    end
    if (d[0] < 0 || d[1] < 0 || d[2] < 0 || d[3] < 0) begin
      mm = -1; ss = -1;
    end else begin
      mm = d[3] * 10 + d[2]; ss = d[1] * 10 + d[0];
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_an;
    int mm, ss;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      n_chk++;
      if ({bus.seg, bus.an, bus.motor, bus.leds, bus.done} !== 20'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: seg=%h an=%b motor=%b leds=%b done=%b expected all 0",
                 bus.seg, bus.an, bus.motor, bus.leds, bus.done);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      exp_an = 4'(1 << (i / 2));
      n_chk++;
      if (bus.an !== exp_an || bus.seg !== 7'h7E) begin
        n_fail++;
        $display("FAIL idle_scan[%0d]: an=%b seg=%h expected an=%b seg=7e", i, bus.an, bus.seg, exp_an);
      end
    end
    read_disp(mm, ss);
    n_chk++;
    if (mm !== 0 || ss !== 0) begin
      n_fail++;
      $display("FAIL idle_display: got %0d:%0d expected 0:0", mm, ss);
    end
    press(0, 0, 1);
    cyc(25);
    n_chk++;
    if (bus.leds !== 4'b0000 || bus.done !== 1'b0 || dut.sec !== 6'd0 || dut.min !== 7'd0) begin
      n_fail++;
      $display("FAIL start_at_zero: leds=%b done=%b time=%0d:%0d expected leds=0000 time 0:0",
               bus.leds, bus.done, dut.min, dut.sec);
    end
  endtask

  task automatic test_set_wrap;
    bit hid, vis, bad;
    int mm, ss;
    press(1, 0, 0);
    cyc(1);
    n_chk++;
    if (bus.leds !== 4'b0001) begin
      n_fail++; $display("FAIL set_min_led: leds=%b expected 0001", bus.leds);
    end
    press(0, 1, 0);
    press(0, 1, 0);
    hid = 0; vis = 0; bad = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1);
      if (bus.an[3] || bus.an[2]) begin
        if (bus.seg === 7'h00) hid = 1;
        else if (bus.seg === (bus.an[3] ? 7'h7E : 7'h6D)) vis = 1;
        else bad = 1;
      end else if (bus.seg !== 7'h7E) bad = 1;
    end
    n_chk++;
    if (hid !== 1'b1 || vis !== 1'b1 || bad !== 1'b0) begin
      n_fail++;
      $display("FAIL min_blink: hidden=%0d visible=%0d bad=%0d expected 1 1 0", hid, vis, bad);
    end
    press(1, 0, 0);
    cyc(1);
    n_chk++;
    if (bus.leds !== 4'b0010) begin
      n_fail++; $display("FAIL set_sec_led: leds=%b expected 0010", bus.leds);
    end
    repeat (61) press(0, 1, 0);
    press(1, 0, 0);
    cyc(1);
    n_chk++;
    if (bus.leds !== 4'b0000 || dut.min !== 7'd2 || dut.sec !== 6'd1) begin
      n_fail++;
      $display("FAIL set_result: leds=%b time=%0d:%0d expected 0000 2:1", bus.leds, dut.min, dut.sec);
    end
    read_disp(mm, ss);
    n_chk++;
    if (mm !== 2 || ss !== 1) begin
      n_fail++; $display("FAIL set_display: got %0d:%0d expected 2:1", mm, ss);
    end
  endtask

  task automatic test_min_wrap;
    press(1, 0, 0);
    repeat (57) press(0, 1, 0);
    n_chk++;
    if (dut.min !== 7'd59) begin
      n_fail++; $display("FAIL min_max: min=%0d expected 59", dut.min);
    end
    press(0, 1, 0);
    n_chk++;
    if (dut.min !== 7'd0) begin
      n_fail++; $display("FAIL min_wrap: min=%0d expected 0", dut.min);
    end
    press(1, 0, 0);
    press(1, 0, 0);
  endtask

  task automatic test_countdown;
    bit hid [4];
    bit vis [4];
    bit bad;
    int mm, ss;
    set_time(0, 1, 1, 0);
    press(0, 0, 1);
    cyc(1);
    n_chk++;
    if (bus.motor !== 4'b1100 || bus.leds !== 4'b0100) begin
      n_fail++; $display("FAIL run_start: motor=%b leds=%b expected 1100 0100", bus.motor, bus.leds);
    end
    cyc(4);
    n_chk++;
    if (bus.motor !== 4'b1100) begin
      n_fail++; $display("FAIL motor_hold: motor=%b expected 1100", bus.motor);
    end
    cyc(1);
    n_chk++;
    if (bus.motor !== 4'b0110) begin
      n_fail++; $display("FAIL motor_step1: motor=%b expected 0110", bus.motor);
    end
    cyc(5);
    n_chk++;
    if (bus.motor !== 4'b0011) begin
      n_fail++; $display("FAIL motor_step2: motor=%b expected 0011", bus.motor);
    end
    cyc(8);
    n_chk++;
    if (dut.min !== 7'd1 || dut.sec !== 6'd0) begin
      n_fail++; $display("FAIL pre_tick: time=%0d:%0d expected 1:0", dut.min, dut.sec);
    end
    cyc(1);
    n_chk++;
    if (dut.min !== 7'd0 || dut.sec !== 6'd59) begin
      n_fail++; $display("FAIL borrow: time=%0d:%0d expected 0:59", dut.min, dut.sec);
    end
    read_disp(mm, ss);
    n_chk++;
    if (mm !== 0 || ss !== 59) begin
      n_fail++; $display("FAIL run_display: got %0d:%0d expected 0:59", mm, ss);
    end
    cyc(1171);
    n_chk++;
    if (dut.sec !== 6'd1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL last_second: sec=%0d done=%b expected 1 0", dut.sec, bus.done);
    end
    cyc(2);
    n_chk++;
    if (bus.done !== 1'b1 || bus.motor !== 4'b0000 || bus.leds !== 4'b0000 || dut.sec !== 6'd0) begin
      n_fail++;
      $display("FAIL done_state: done=%b motor=%b leds=%b sec=%0d expected 1 0000 0000 0",
               bus.done, bus.motor, bus.leds, dut.sec);
    end
    hid = '{0, 0, 0, 0}; vis = '{0, 0, 0, 0}; bad = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1);
      for (int j = 0; j < 4; j++) if (bus.an[j]) begin
        if (bus.seg === 7'h00) hid[j] = 1;
        else if (bus.seg === 7'h7E) vis[j] = 1;
        else bad = 1;
      end
    end
    n_chk++;
    if ({hid[3], hid[2], hid[1], hid[0], vis[3], vis[2], vis[1], vis[0], bad} !== 9'b111111110) begin
      n_fail++;
      $display("FAIL done_blink: hidden=%b%b%b%b visible=%b%b%b%b bad=%b expected 1111 1111 0",
               hid[3], hid[2], hid[1], hid[0], vis[3], vis[2], vis[1], vis[0], bad);
    end
    press(0, 1, 0);
    cyc(1);
    n_chk++;
    if (bus.done !== 1'b0 || bus.leds !== 4'b0000 || dut.min !== 7'd0 || dut.sec !== 6'd0) begin
      n_fail++; $display("FAIL done_exit: done=%b leds=%b expected 0 0000", bus.done, bus.leds);
    end
  endtask

  task automatic test_sensor_pause;
    set_time(0, 0, 0, 30);
    press(0, 0, 1);
    cyc(18);
    bus.sensor = 1'b1;
    cyc(2);
    n_chk++;
    if (dut.sec !== 6'd30) begin
      n_fail++; $display("FAIL pause_vs_tick: sec=%0d expected 30", dut.sec);
    end
    cyc(1);
    n_chk++;
    if (bus.leds !== 4'b1000 || bus.motor !== 4'b0000) begin
      n_fail++; $display("FAIL pause_out: leds=%b motor=%b expected 1000 0000", bus.leds, bus.motor);
    end
    press(0, 0, 1);
    cyc(25);
    n_chk++;
    if (bus.leds !== 4'b1000 || dut.sec !== 6'd30) begin
      n_fail++; $display("FAIL start_blocked: leds=%b sec=%0d expected 1000 30", bus.leds, dut.sec);
    end
    bus.sensor = 1'b0;
    cyc(2);
    press(0, 0, 1);
    n_chk++;
    if (dut.sec !== 6'd30) begin
      n_fail++; $display("FAIL resume_hold: sec=%0d expected 30", dut.sec);
    end
    cyc(1);
    n_chk++;
    if (dut.sec !== 6'd29 || bus.leds !== 4'b0100) begin
      n_fail++; $display("FAIL resume_partial: sec=%0d leds=%b expected 29 0100", dut.sec, bus.leds);
    end
    press(0, 0, 1);
    press(1, 0, 0);
    cyc(1);
    n_chk++;
    if (bus.leds !== 4'b0000 || dut.sec !== 6'd29) begin
      n_fail++; $display("FAIL pause_to_idle: leds=%b sec=%0d expected 0000 29", bus.leds, dut.sec);
    end
  endtask

  task automatic test_simultaneous;
    set_time(0, 29, 0, 5);
    press(1, 0, 1);
    cyc(1);
    n_chk++;
    if (bus.leds !== 4'b0001) begin
      n_fail++; $display("FAIL set_wins: leds=%b expected 0001", bus.leds);
    end
    cyc(40);
    n_chk++;
    if (dut.sec !== 6'd5 || bus.leds !== 4'b0001) begin
      n_fail++; $display("FAIL no_countdown: sec=%0d leds=%b expected 5 0001", dut.sec, bus.leds);
    end
    press(1, 0, 0);
    press(1, 0, 0);
  endtask

  task automatic test_reset_midrun;
    set_time(0, 5, 0, 10);
    press(0, 0, 1);
    cyc(5);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    n_chk++;
    if (dut.min !== 7'd0 || dut.sec !== 6'd0 || bus.motor !== 4'b0000 || bus.done !== 1'b0 ||
        bus.leds !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_midrun: time=%0d:%0d motor=%b done=%b leds=%b expected 0:0 0000 0 0000",
               dut.min, dut.sec, bus.motor, bus.done, bus.leds);
    end
    cyc(25);
    n_chk++;
    if (dut.sec !== 6'd0 || bus.leds !== 4'b0000 || bus.motor !== 4'b0000) begin
      n_fail++; $display("FAIL reset_idle: sec=%0d leds=%b motor=%b expected 0 0000 0000",
                         dut.sec, bus.leds, bus.motor);
    end
  endtask

  initial begin
    bus.btn_set = 0; bus.btn_up = 0; bus.btn_start = 0; bus.sensor = 0;
    test_reset();
    test_set_wrap();
    test_min_wrap();
    test_countdown();
    test_sensor_pause();
    test_simultaneous();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
- Parametrised MM:SS countdown timer controller: button-driven set mode, run/pause/done FSM, stepper-motor drive while running, and a multiplexed 4-digit seven-segment driver with blinking of the field being edited.
- Sits directly behind the debounced push-button / sensor inputs and drives the board display, indicator LEDs and motor phases.
- Replaces separate clock-divider, setter, blink, selector and BCD instances with one block.
- All rates are parameterised as cycle counts so the bench can run with small values.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per one-second countdown tick.
- SCAN_DIV, 62_500, clk cycles each digit stays enabled.
- BLINK_DIV, 10_000_000, clk cycles per blink half-period.
- STEP_DIV, 250_000, clk cycles per motor step.
- MAX_MIN, 59, highest settable minute value (1..99).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- btn_set  in  1  debounced level, active-high; cycles the set fields
- btn_up  in  1  debounced level, active-high; increments the field being edited
- btn_start  in  1  debounced level, active-high; start/pause/resume
- sensor  in  1  active-high interlock; 1 forces pause
- seg  out  7  segments a..g (seg[6]=a), active-high, registered
- an  out  4  one-hot digit enable, an[3]=min tens … an[0]=sec units, registered
- leds  out  4  [0]=SET_MIN, [1]=SET_SEC, [2]=RUN, [3]=PAUSE
- motor  out  4  stepper phase outputs, registered
- done  out  1  high while in DONE

Behaviour:
- Reset is synchronous: rst_n=0 sampled on a clk edge. Effects:
  - min=0, sec=0, state=IDLE.
  - All dividers, scan index and step index = 0; blink phase = visible.
  - Outputs: seg=0, an=0, leds=0, motor=0, done=0.
  - Reset mid-RUN aborts immediately; no motor step on that edge.
- Buttons: each input is registered once. A press is the rising edge of the registered value, giving 1 action per press. If several edges occur in the same cycle, priority is btn_set > btn_start > btn_up; the lower-priority edges are dropped.
- FSM:
  - IDLE: set → SET_MIN. start → RUN only if time≠00:00; otherwise ignored.
  - SET_MIN: up → min+1, wrapping MAX_MIN→0. set → SET_SEC. Minute digits blink.
  - SET_SEC: up → sec+1, wrapping 59→0. set → IDLE. Second digits blink.
  - RUN: on each tick, sec-1. If sec=0: sec=59 and min-1.
    - Reaching 00:00 → DONE on the same edge.
    - sensor=1 or start → PAUSE. Pause has priority over a tick in the same cycle, so no decrement occurs.
    - set is ignored.
  - PAUSE: tick counter frozen. start with sensor=0 → RUN, resuming the partial second. set → IDLE with time kept.
  - DONE: done=1; all four digits blink. Any button edge → IDLE with time 00:00.
- Tick counter: cleared on entry to RUN from IDLE. The first decrement lands TICK_DIV cycles after the start edge.
- Motor:
  - In RUN, the step index advances every STEP_DIV cycles.
  - Phase sequence: 1100 → 0110 → 0011 → 1001 → repeat.
  - In every other state, motor=0000. The step index is retained across PAUSE and cleared on entry to DONE.
- Display:
  - Scan index increments every SCAN_DIV cycles, 0→1→2→3→0.
  - an = one-hot of the scan index; seg = decode of the selected BCD digit.
  - Min and sec are converted to BCD tens/units by divide/modulo 10.
  - Decode: 0–9 standard patterns.
  - A digit that is in a blinking field while the blink phase is "hidden" drives seg=0; an keeps scanning.
  - Blink phase toggles every BLINK_DIV cycles and is free-running.
  - Display outputs lag internal state by 1 cycle.
- leds are registered decodes of the state. done is registered.
- Width rules:
  - min is 7 bits, sec 6 bits; neither can exceed its max.
  - All divider counters are sized with $clog2 of their parameter and wrap at DIV-1.

Test Plan:
Common parameters: TICK_DIV=20, SCAN_DIV=2, BLINK_DIV=8, STEP_DIV=5.
- Reset/idle: hold rst_n=0 for 3 cycles, then release → seg=0, an=0 and motor=0 during reset. After release, an scans 0001,0010,0100,1000 at 2 cycles each; display shows 00:00. A start press leaves state in IDLE.
- Set and wrap: set, up×2, set, up×61, set → time 02:01 (second value wraps 59→0 once). leds[0] high in SET_MIN, leds[1] high in SET_SEC. Minute digits show seg=0 during hidden phases in SET_MIN.
- Countdown/borrow: time 01:00, start → 00:59 after 20 cycles. motor steps 1100→0110 every 5 cycles. After 60 ticks total → DONE, done=1, motor=0000, all digits blinking. Any press → IDLE.
- Sensor pause: in RUN at 00:30, assert sensor coincident with a tick → PAUSE, time stays 00:30, motor=0, leds[3]=1. A start press while sensor=1 stays in PAUSE. Drop sensor, then start → RUN, with the next tick after the remaining partial count.
- Simultaneous buttons: in IDLE with time 00:05, set and start rise together → SET_MIN (set wins); no countdown occurs.
- Reset mid-run: rst_n=0 for 1 cycle during RUN at 00:10 → next cycle state=IDLE, time 00:00, motor=0, done=0.
